// File: rtl/shadow_stack_ctrl.sv
// Return-address shadow stack: checks committed returns against the pushed call sites.
// Define SHADOW_STACK_SPILL_EN to spill the oldest entries to memory and refill them on demand.

package riscv;
    localparam int VLEN = 64;
    localparam int XLEN = 64;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    localparam logic [XLEN-1:0] CAUSE_SW_CHECK = 64'd18;
    localparam logic [XLEN-1:0] TVAL_SS_FAULT  = 64'd3;
endpackage

module shadow_stack_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   push_valid_i,
    input  logic [riscv::VLEN-1:0] push_addr_i,
    input  logic                   pop_valid_i,
    input  logic [riscv::VLEN-1:0] pop_addr_i,
    output logic                   ready_o,
    output riscv::exception_t      popchk_ex_o,
    input  logic [riscv::VLEN-1:0] ssp_base_i,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [riscv::VLEN-1:0] mem_addr_o,
    output logic [riscv::VLEN-1:0] mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [riscv::VLEN-1:0] mem_rdata_i
);
    // state     | meaning
    // IDLE      | push/pop events accepted and checked
    // SPILL     | oldest entry written to the spill area, held until grant
    // FILL      | most recently spilled entry requested, held until grant
    // FILL_WAIT | waiting for the refill read data
    typedef enum logic [1:0] {IDLE, SPILL, FILL, FILL_WAIT} state_e;

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    state_e                 state_q, state_d;
    logic [riscv::VLEN-1:0] stack_q [DEPTH];
    logic [PW-1:0]          bot_q;
    logic [PW:0]            count_q;
    logic [CNT_W-1:0]       mem_cnt_q;

    logic [PW-1:0] top_idx, free_idx;
    logic          full, empty, ready_core, evt_ok;
    logic          push_acc, pop_acc, pop_fault, push_fault, fault;

    assign free_idx = bot_q + count_q[PW-1:0];
    assign top_idx  = free_idx - PW'(1);
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);

`ifdef SHADOW_STACK_SPILL_EN
    logic             mem_sat, mem_nz;
    logic [CNT_W-1:0] fill_idx;

    assign mem_sat  = &mem_cnt_q;
    assign mem_nz   = |mem_cnt_q;
    assign fill_idx = mem_cnt_q - CNT_W'(1);
    // With the spill counter saturated the push is let through so it can fault instead of stalling.
    assign ready_core = (state_q == IDLE) && (!full || mem_sat) && !(empty && mem_nz);
`else
    logic unused_spill;

    assign ready_core   = 1'b1;
    assign unused_spill = ^{ssp_base_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_cnt_q, state_q};
`endif

    assign ready_o    = !rst_ni || !enable_i || ready_core;
    assign evt_ok     = rst_ni && enable_i && ready_core;
    assign push_acc   = evt_ok && push_valid_i;
    assign pop_acc    = evt_ok && pop_valid_i;
    assign pop_fault  = pop_acc && (empty || (pop_addr_i != stack_q[top_idx]));
    assign push_fault = push_acc && !pop_acc && full;
    assign fault      = pop_fault || push_fault;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef SHADOW_STACK_SPILL_EN
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    if (full && !mem_sat) begin
                        state_d = SPILL;
                    end else if (empty && mem_nz) begin
                        state_d = FILL;
                    end
                end
            end
            SPILL:     if (mem_gnt_i) state_d = IDLE;
            FILL:      if (mem_gnt_i) state_d = FILL_WAIT;
            FILL_WAIT: if (mem_rvalid_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
`else
        state_d = IDLE;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bot_q     <= '0;
            count_q   <= '0;
            mem_cnt_q <= '0;
        end else begin
            if (push_acc && !fault) begin
                if (pop_acc) begin
                    stack_q[top_idx] <= push_addr_i;
                end else begin
                    stack_q[free_idx] <= push_addr_i;
                    count_q           <= count_q + 1'b1;
                end
            end else if (pop_acc && !fault) begin
                count_q <= count_q - 1'b1;
            end
`ifdef SHADOW_STACK_SPILL_EN
            if (state_q == SPILL && mem_gnt_i) begin
                bot_q     <= bot_q + 1'b1;
                count_q   <= count_q - 1'b1;
                mem_cnt_q <= mem_cnt_q + 1'b1;
            end
            // Refill only happens with an empty stack, so the new top lands at the oldest slot.
            if (state_q == FILL_WAIT && mem_rvalid_i) begin
                stack_q[bot_q] <= mem_rdata_i;
                count_q        <= (PW+1)'(1);
                mem_cnt_q      <= mem_cnt_q - 1'b1;
            end
`endif
        end
    end

    always_comb begin
        popchk_ex_o = '0;
        if (fault) begin
            popchk_ex_o.valid = 1'b1;
            popchk_ex_o.cause = riscv::CAUSE_SW_CHECK;
            popchk_ex_o.tval  = riscv::TVAL_SS_FAULT;
        end
    end

`ifdef SHADOW_STACK_SPILL_EN
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            SPILL: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = ssp_base_i + riscv::VLEN'({mem_cnt_q, 3'b000});
                mem_wdata_o = stack_q[bot_q];
            end
            FILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = ssp_base_i + riscv::VLEN'({fill_idx, 3'b000});
            end
            default: ;
        endcase
    end
`else
    assign mem_req_o   = 1'b0;
    assign mem_we_o    = 1'b0;
    assign mem_addr_o  = '0;
    assign mem_wdata_o = '0;
`endif

endmodule

// File: doc/shadow_stack_ctrl.md
SHADOW_STACK_CTRL -- requirements
Module: shadow_stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, on-chip shadow-stack entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, width of spilled-entry counter.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port enable_i  in  1  shadow stack enabled (from CSR); when 0, events are ignored and no exception is raised.
REQ-006 SHALL have port push_valid_i  in  1  committed call (link to ra/t0).
REQ-007 SHALL have port push_addr_i  in  riscv::VLEN  return address to push.
REQ-008 SHALL have port pop_valid_i  in  1  committed return.
REQ-009 SHALL have port pop_addr_i  in  riscv::VLEN  actual return target to check.
REQ-010 SHALL have port ready_o  out  1  events accepted this cycle; commit stalls when 0.
REQ-011 SHALL have port popchk_ex_o  out  exception_t  shadow-stack fault to the commit stage.
REQ-012 SHALL have port ssp_base_i  in  riscv::VLEN  memory spill-area base address.
REQ-013 SHALL have ports mem_req_o (out, 1), mem_we_o (out, 1), mem_addr_o (out, VLEN), mem_wdata_o (out, VLEN), mem_gnt_i (in, 1), mem_rvalid_i (in, 1), and mem_rdata_i (in, VLEN), forming the spill/fill memory port.

Function
REQ-014 SHALL hold a circular buffer of DEPTH entries plus count (0..DEPTH) and mem_cnt (CNT_W bits).
REQ-015 SHALL implement FSM states IDLE, SPILL, FILL, FILL_WAIT; events are accepted only in IDLE.
REQ-016 SHALL drive ready_o = IDLE && count<DEPTH && !(count==0 && mem_cnt!=0), or = 1 whenever enable_i=0.
REQ-017 SHALL, on an accepted push, write push_addr_i on top and increment count at the next edge.
REQ-018 SHALL, on an accepted pop, compare pop_addr_i with top combinationally: on match, decrement count at the next edge; on mismatch, raise popchk_ex_o in the same cycle and leave the stack unchanged.
REQ-019 SHALL, on a pop with count==0 and mem_cnt==0, raise popchk_ex_o (underflow) and leave the stack unchanged.
REQ-020 SHALL drive popchk_ex_o.valid=1, cause=18 (software check) and tval=3 on a fault; otherwise all fields are 0; the output is combinational and never registered.
REQ-021 SHALL, on simultaneous push and pop, check the pop against the old top first; if no fault, top is replaced by push_addr_i and count is unchanged; a fault suppresses the push.
REQ-022 SHALL, in IDLE with count==DEPTH and mem_cnt<2^CNT_W-1, enter SPILL.
REQ-023 SHALL, in SPILL, assert mem_req_o=1 and mem_we_o=1, with mem_addr_o=ssp_base_i+mem_cnt*8 and mem_wdata_o=oldest entry; on mem_gnt_i it SHALL drop the oldest entry, do count-1 and mem_cnt+1, and return to IDLE.
REQ-024 SHALL, in IDLE with count==0 and mem_cnt!=0, enter FILL.
REQ-025 SHALL, in FILL, assert mem_req_o=1 and mem_we_o=0, with mem_addr_o=ssp_base_i+(mem_cnt-1)*8; on mem_gnt_i it SHALL go to FILL_WAIT.
REQ-026 SHALL, in FILL_WAIT, on mem_rvalid_i write mem_rdata_i as the top entry, set count=1, do mem_cnt-1, and return to IDLE.
REQ-027 SHALL, on a push with count==DEPTH and mem_cnt saturated, raise popchk_ex_o (overflow) and drop the push.
REQ-028 SHALL hold mem_req_o, mem_addr_o and mem_we_o stable until mem_gnt_i is received.
REQ-029 SHALL, with enable_i=0, stay in IDLE or finish any in-flight SPILL/FILL, with no new transitions.

Reset
REQ-030 SHALL, on rst_ni=0 at a clock edge, set state=IDLE, count=0, mem_cnt=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, and popchk_ex_o=0.
REQ-031 SHALL, on reset during SPILL/FILL/FILL_WAIT, abandon the transaction, deassert mem_req_o from the next cycle, and ignore a late mem_rvalid_i.
REQ-032 SHALL drive ready_o=1 during and after reset, following REQ-016 with count=0 and mem_cnt=0.

Configuration
REQ-033 SHALL honour macro SHADOW_STACK_SPILL_EN: when defined, spill/fill operates per REQ-022..REQ-026.
REQ-034 SHALL, with SHADOW_STACK_SPILL_EN undefined, tie mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o to 0, never leave IDLE, drive ready_o=1, raise overflow on a push with count==DEPTH, and raise underflow on a pop with count==0.

Verification
REQ-035 SHALL cover: push 0x8000_0100, then pop 0x8000_0100 -> no fault; count returns to 0.
REQ-036 SHALL cover: push 0x8000_0100, then pop 0x8000_0200 -> popchk_ex_o valid, cause 18, tval 3, same cycle; count stays 1.
REQ-037 SHALL cover: 9 pushes with DEPTH=8 and ssp_base_i=0x1000 -> SPILL write to 0x1000 of the first address; ready_o low until gnt; mem_cnt=1.
REQ-038 SHALL cover: after REQ-037, 9 matching pops -> FILL read at 0x1000; rdata returned; 9th pop passes; mem_cnt=0.
REQ-039 SHALL cover: simultaneous push 0xA0 and pop matching top 0x90 -> top=0xA0, count unchanged; with a mismatched pop -> fault, and the push is dropped.
REQ-040 SHALL cover: reset asserted in FILL_WAIT, followed by a late mem_rvalid_i -> all state 0, rdata ignored, mem_req_o=0.
